// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide engine feeding the HI/LO write path.
// One iteration per cycle: 1 load edge, 32 CALC edges, 1 FIX edge.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_quo_q, sgn_quo_d;
  logic        sgn_rem_q, sgn_rem_d;
  logic        div0_q, div0_d;
  logic        done_q, done_d;
  logic [63:0] result_q, result_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [31:0] quot_sh;
  logic [31:0] rem_diff;
  logic        no_borrow;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Unsigned magnitude; |0x80000000| stays 0x80000000 as a 32-bit unsigned value.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? neg32(x) : x;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == 5'd0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    mag_a     = mag32(a, ~op[0]);
    mag_b     = mag32(b, ~op[0]);
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    rem_sh    = acc_q[63:31];
    quot_sh   = {acc_q[30:0], 1'b0};
    no_borrow = (rem_sh >= {1'b0, opnd_q});
    rem_diff  = rem_sh[31:0] - opnd_q;

    prod_fix = acc_q;
    quo_fix  = acc_q[31:0];
    rem_fix  = acc_q[63:32];
    if (!op_q[0]) begin
      if (sgn_quo_q) prod_fix = neg64(acc_q);
      if (sgn_quo_q) quo_fix  = neg32(acc_q[31:0]);
      if (sgn_rem_q) rem_fix  = neg32(acc_q[63:32]);
    end
    // Divide by zero: remainder path already restores the original dividend.
    if (div0_q) quo_fix = 32'hFFFF_FFFF;

    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          sgn_quo_d = a[31] ^ b[31];
          sgn_rem_d = a[31];
          div0_d    = op[1] && (b == 32'd0);
          cnt_d     = 5'd31;
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {32'd0, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {32'd0, mag_b};
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - 5'd1;
        if (!op_q[1]) begin
          acc_d = {mul_sum, acc_q[31:1]};
        end else if (no_borrow) begin
          acc_d = {rem_diff, quot_sh[31:1], 1'b1};
        end else begin
          acc_d = {rem_sh[31:0], quot_sh};
        end
      end
      FIX: begin
        done_d   = 1'b1;
        result_d = op_q[1] ? {rem_fix, quo_fix} : prod_fix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 2'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 5'd0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases plus randomized ops checked
// against a plain-arithmetic reference of the HI/LO result.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;

  mul_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint          sx, sy, sq, sm;
    longint unsigned ux, uy, uq, um;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: r = sx * sy;
      2'd1: r = ux * uy;
      2'd2: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sm = sx % sy;
          r  = {sm[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          um = ux % uy;
          r  = {um[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Called #1 after an edge; returns #1 after the start edge with garbage on the inputs.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("done_clear", {63'd0, done}, 64'd0);
  endtask

  task automatic await_done(input int elapsed, output int lat);
    logic busy_bad;
    busy_bad = 1'b0;
    lat      = elapsed;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && !busy) busy_bad = 1'b1;
    end
    chk("busy_hold", {63'd0, busy_bad}, 64'd0);
    chk("latency", 64'(lat), 64'd33);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    int lat;
    issue(o, x, y);
    await_done(0, lat);
    chk(tag, result, ref_res(o, x, y));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    logic        seen_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);

    run_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg3x7_const", result, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_const", result, 64'hFFFF_FFFE_0000_0001);
    run_op("divu_b2b", 2'd3, 32'd100, 32'd7);
    chk("divu_b2b_const", result, 64'h0000_0002_0000_000E);

    run_op("div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg7by2_const", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", result, 64'h0000_0000_8000_0000);
    run_op("divu_by0", 2'd3, 32'd5, 32'd0);
    chk("divu_by0_const", result, 64'h0000_0005_FFFF_FFFF);
    run_op("div_neg5_by0", 2'd2, 32'hFFFF_FFFB, 32'd0);
    chk("div_neg5_by0_const", result, 64'hFFFF_FFFB_FFFF_FFFF);

    // start while busy must be ignored
    issue(2'd0, 32'd3, 32'd4);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op    = 2'd2;
    a     = 32'd1000;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    await_done(10, lat);
    chk("start_ignored", result, 64'h0000_0000_0000_000C);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_after_ignored", {63'd0, busy}, 64'd0);
    chk("result_hold", result, 64'h0000_0000_0000_000C);

    // reset in flight discards the operation
    issue(2'd1, 32'd2, 32'd2);
    repeat (13) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_result", result, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("no_done_after_rst", {63'd0, seen_done}, 64'd0);
    run_op("after_rst", 2'd1, 32'd2, 32'd2);
    chk("after_rst_const", result, 64'd4);

    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
